// File: rtl/program_loader.sv
// ============================================================================
// program_loader: streams NUM_WORDS bytes from pins into RAM over the shared
// bus while holding the CPU in reset. The optional running checksum output is
// enabled by defining LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module program_loader #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 4,
    parameter int NUM_WORDS   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_req,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              n_load_addr,
    output logic              n_load_data,
    output logic              n_ram_we,
    output logic              cpu_rst_n,
    output logic              data_ack,
    output logic              busy,
    output logic              done,
    output logic              overrun,
`ifdef LOADER_CHECKSUM_EN
    output logic [ADDR_W:0]   word_count,
    output logic [DATA_W-1:0] checksum
`else
    output logic [ADDR_W:0]   word_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BYTE = 3'd1,
        S_ADDR      = 3'd2,
        S_DATA      = 3'd3,
        S_WRITE     = 3'd4,
        S_NEXT      = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   C_WC_ONE    = (ADDR_W + 1)'(1);

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W:0]          word_count_q, word_count_d;
    logic [DATA_W-1:0]        data_reg_q, data_reg_d;
    logic                     overrun_q, overrun_d;
    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     vld_prev_q, vld_prev_d;
    logic                     vld_edge_q, vld_edge_d;

    logic [DATA_W-1:0]        bus_out_q, bus_out_d;
    logic                     bus_oe_q, bus_oe_d;
    logic                     n_load_addr_q, n_load_addr_d;
    logic                     n_load_data_q, n_load_data_d;
    logic                     n_ram_we_q, n_ram_we_d;
    logic                     cpu_rst_n_q, cpu_rst_n_d;
    logic                     data_ack_q, data_ack_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]        checksum_q, checksum_d;
`endif

    // data_valid is asynchronous: synchronize, then register a one-cycle rise pulse
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], data_valid};
        vld_prev_d = sync_q[SYNC_STAGES-1];
        vld_edge_d = sync_q[SYNC_STAGES-1] & ~vld_prev_q;
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        data_reg_d   = data_reg_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (load_req) begin
                    state_d      = S_WAIT_BYTE;
                    word_count_d = '0;
                    overrun_d    = 1'b0;
                end
            end
            S_WAIT_BYTE: begin
                if (!load_req) begin
                    state_d = S_IDLE;
                end else if (vld_edge_q) begin
                    data_reg_d = data_in;
                    state_d    = S_ADDR;
                end
            end
            S_ADDR:  state_d = load_req ? S_DATA  : S_IDLE;
            S_DATA:  state_d = load_req ? S_WRITE : S_IDLE;
            S_WRITE: state_d = load_req ? S_NEXT  : S_IDLE;
            S_NEXT: begin
                word_count_d = word_count_q + C_WC_ONE;
                if (!load_req) begin
                    state_d = S_IDLE;
                end else if (addr_q == C_LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + C_ADDR_ONE;
                    state_d = S_WAIT_BYTE;
                end
            end
            S_DONE: begin
                if (!load_req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte arriving while the write sequence is busy cannot be stored
        if (vld_edge_q && (state_q inside {S_ADDR, S_DATA, S_WRITE, S_NEXT, S_DONE})) begin
            overrun_d = 1'b1;
        end

        if (state_d == S_IDLE) begin
            addr_d = '0;
        end
    end

    // Outputs decode the next state so every strobe comes straight from a flop
    always_comb begin
        bus_out_d     = '0;
        bus_oe_d      = 1'b0;
        n_load_addr_d = 1'b1;
        n_load_data_d = 1'b1;
        n_ram_we_d    = 1'b1;
        data_ack_d    = 1'b0;
        cpu_rst_n_d   = (state_d == S_IDLE);
        busy_d        = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d        = (state_d == S_DONE);

        unique case (state_d)
            S_ADDR: begin
                bus_oe_d      = 1'b1;
                bus_out_d     = DATA_W'(addr_d);
                n_load_addr_d = 1'b0;
            end
            S_DATA: begin
                bus_oe_d      = 1'b1;
                bus_out_d     = data_reg_d;
                n_load_data_d = 1'b0;
            end
            S_WRITE: n_ram_we_d = 1'b0;
            S_NEXT:  data_ack_d = 1'b1;
            default: ;
        endcase
    end

`ifdef LOADER_CHECKSUM_EN
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == S_IDLE) && load_req) begin
            checksum_d = '0;
        end else if (state_q == S_NEXT) begin
            checksum_d = checksum_q + data_reg_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            word_count_q  <= '0;
            data_reg_q    <= '0;
            overrun_q     <= 1'b0;
            sync_q        <= '0;
            vld_prev_q    <= 1'b0;
            vld_edge_q    <= 1'b0;
            bus_out_q     <= '0;
            bus_oe_q      <= 1'b0;
            n_load_addr_q <= 1'b1;
            n_load_data_q <= 1'b1;
            n_ram_we_q    <= 1'b1;
            cpu_rst_n_q   <= 1'b1;
            data_ack_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            word_count_q  <= word_count_d;
            data_reg_q    <= data_reg_d;
            overrun_q     <= overrun_d;
            sync_q        <= sync_d;
            vld_prev_q    <= vld_prev_d;
            vld_edge_q    <= vld_edge_d;
            bus_out_q     <= bus_out_d;
            bus_oe_q      <= bus_oe_d;
            n_load_addr_q <= n_load_addr_d;
            n_load_data_q <= n_load_data_d;
            n_ram_we_q    <= n_ram_we_d;
            cpu_rst_n_q   <= cpu_rst_n_d;
            data_ack_q    <= data_ack_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign bus_out     = bus_out_q;
    assign bus_oe      = bus_oe_q;
    assign n_load_addr = n_load_addr_q;
    assign n_load_data = n_load_data_q;
    assign n_ram_we    = n_ram_we_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    assign data_ack    = data_ack_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign overrun     = overrun_q;
    assign word_count  = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader: directed bench for program_loader with a bus scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_program_loader;

    logic       clk;
    logic       rst_n;
    logic       load_req;
    logic [7:0] data_in;
    logic       data_valid;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       n_load_addr;
    logic       n_load_data;
    logic       n_ram_we;
    logic       cpu_rst_n;
    logic       data_ack;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [4:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    program_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_req    (load_req),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .bus_out     (bus_out),
        .bus_oe      (bus_oe),
        .n_load_addr (n_load_addr),
        .n_load_data (n_load_data),
        .n_ram_we    (n_ram_we),
        .cpu_rst_n   (cpu_rst_n),
        .data_ack    (data_ack),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
`ifdef LOADER_CHECKSUM_EN
        .word_count  (word_count),
        .checksum    (checksum)
`else
        .word_count  (word_count)
`endif
    );

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fails   = 0;
    int   ack_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: every strobe is matched against the scoreboard
    always @(negedge clk) begin
        if (data_ack) ack_count++;
        if (!n_load_addr || !n_load_data || !n_ram_we) begin
            check("strobe_exclusive",
                  32'(int'(!n_load_addr) + int'(!n_load_data) + int'(!n_ram_we)), 1);
        end
        if (!n_load_addr) begin
            check("addr_strobe_expected", 32'(sb.size() > 0), 1);
            check("addr_bus_oe", bus_oe, 1);
            if (sb.size() > 0) check("addr_bus_out", bus_out, {4'h0, sb[0].addr});
        end
        if (!n_load_data) begin
            check("data_strobe_expected", 32'(sb.size() > 0), 1);
            check("data_bus_oe", bus_oe, 1);
            if (sb.size() > 0) begin
                check("data_bus_out", bus_out, sb[0].data);
                void'(sb.pop_front());
            end
        end
        if (!n_ram_we) check("we_bus_released", bus_oe, 0);
    end

    task automatic send_byte(input logic [3:0] addr, input logic [7:0] data);
        exp_t e;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
        data_in    = data;
        data_valid = 1'b1;
        repeat (3) @(negedge clk);
        data_valid = 1'b0;
        repeat (11) @(negedge clk);
    endtask

    initial begin
        logic found;
        rst_n      = 1'b0;
        load_req   = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_bus_oe", bus_oe, 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_strobes", {n_load_addr, n_load_data, n_ram_we}, 3'b111);
        check("rst_cpu_rst_n", cpu_rst_n, 1);
        check("rst_flags", {data_ack, busy, done, overrun}, 4'b0000);
        check("rst_word_count", word_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cpu_rst_n", cpu_rst_n, 1);
        check("idle_busy", busy, 0);

        // Full 16-byte load
        load_req = 1'b1;
        repeat (2) @(negedge clk);
        check("load_busy", busy, 1);
        check("load_cpu_held", cpu_rst_n, 0);
        for (int k = 0; k < 16; k++) send_byte(4'(k), 8'(8'h10 + k));
        check("full_word_count", word_count, 16);
        check("full_done", done, 1);
        check("full_busy", busy, 0);
        check("full_cpu_held", cpu_rst_n, 0);
        check("full_acks", ack_count, 16);
        check("full_sb_drained", sb.size(), 0);
        check("full_overrun", overrun, 0);
`ifdef LOADER_CHECKSUM_EN
        check("full_checksum", checksum, 8'h78);
`endif

        // Release after done
        load_req = 1'b0;
        @(negedge clk);
        check("release_cpu_rst_n", cpu_rst_n, 1);
        check("release_done", done, 0);
        check("release_word_count", word_count, 16);

        // Second load with an overrun during byte 3
        repeat (2) @(negedge clk);
        load_req = 1'b1;
        repeat (2) @(negedge clk);
        check("reload_word_count", word_count, 0);
        check("reload_overrun", overrun, 0);
        for (int k = 0; k < 3; k++) send_byte(4'(k), 8'(8'h20 + k));
        begin
            exp_t e;
            e.addr = 4'd3;
            e.data = 8'h23;
            sb.push_back(e);
        end
        data_in    = 8'h23;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        data_valid = 1'b1;
        repeat (3) @(negedge clk);
        data_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("ovr_flag", overrun, 1);
        check("ovr_word_count", word_count, 4);
        check("ovr_acks", ack_count, 20);
        check("ovr_busy", busy, 1);
        send_byte(4'd4, 8'h24);
        check("ovr5_word_count", word_count, 5);

        // Abort in WAIT_BYTE
        load_req = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bus_oe", bus_oe, 0);
        check("abort_cpu_rst_n", cpu_rst_n, 1);
        check("abort_word_count", word_count, 5);
        check("abort_overrun_sticky", overrun, 1);
        check("abort_sb_drained", sb.size(), 0);

        // Asynchronous reset during WRITE
        repeat (2) @(negedge clk);
        load_req = 1'b1;
        repeat (2) @(negedge clk);
        begin
            exp_t e;
            e.addr = 4'd0;
            e.data = 8'h5A;
            sb.push_back(e);
        end
        data_in    = 8'h5A;
        data_valid = 1'b1;
        repeat (3) @(negedge clk);
        data_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!n_ram_we) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("write_reached", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_n_ram_we", n_ram_we, 1);
        check("arst_bus_oe", bus_oe, 0);
        check("arst_busy", busy, 0);
        check("arst_cpu_rst_n", cpu_rst_n, 1);
        check("arst_word_count", word_count, 0);
        check("arst_overrun", overrun, 0);
        load_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_arst_idle", {busy, done, bus_oe}, 3'b000);
        check("final_acks", ack_count, 21);
        check("final_sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
